// File: rtl/axi_lite_regfile_bridge_if.sv
// AXI4-Lite slave-side bundle for the register-file bridge.
// The slave modport is the bridge's view; the master modport is the interconnect's view.
interface axi_lite_regfile_bridge_if #(
  parameter int DATA_W = 8,
  parameter int AXI_AW = 8
);
  logic [AXI_AW-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  logic [AXI_AW-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_regfile_bridge.sv
// AXI4-Lite slave that serialises single reads/writes onto the register file's
// WrEn/Address/WrData/RdEn/RdData port with fixed response latency.
//
// Handshakes: a transfer occurs on a cycle where valid && ready are both high.
// Valids from this block are held, with payload stable, until that cycle; the
// ready outputs are combinational and only asserted in IDLE.
module axi_lite_regfile_bridge #(
  parameter int DATA_W = 8,
  parameter int ADDR   = 6,
  parameter int DEPTH  = 6,
  parameter int AXI_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  axi_lite_regfile_bridge_if.slave s,
  output logic                WrEn,
  output logic [ADDR-1:0]     Address,
  output logic [DATA_W-1:0]   WrData,
  output logic                RdEn,
  input  logic [DATA_W-1:0]   RdData,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_RESP = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_e;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [ADDR:0] DEPTH_V     = (ADDR+1)'(DEPTH);

  state_e            state_q, state_d;
  logic              wren_q, wren_d;
  logic              rden_q, rden_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bad_q, bad_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_first_q, rd_first_d;
  logic              aw_bad, ar_bad;

  function automatic logic addr_bad(input logic [AXI_AW-1:0] a);
    logic [ADDR:0] idx;
    idx = {1'b0, a[ADDR-1:0]};
    return ((a >> ADDR) != '0) || (idx >= DEPTH_V);
  endfunction

  assign aw_bad = addr_bad(s.s_awaddr);
  assign ar_bad = addr_bad(s.s_araddr);

  always_comb begin
    state_d     = state_q;
    wren_d      = 1'b0;
    rden_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bad_d       = bad_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    rd_first_d  = (state_q == RD_WAIT);
    s.s_awready = 1'b0;
    s.s_wready  = 1'b0;
    s.s_arready = 1'b0;
    case (state_q)
      IDLE: begin
        if (s.s_awvalid && s.s_wvalid) begin
          s.s_awready = 1'b1;
          s.s_wready  = 1'b1;
          wdata_d     = s.s_wdata;
          bad_d       = aw_bad;
          bresp_d     = aw_bad ? RESP_SLVERR : RESP_OKAY;
          wren_d      = !aw_bad && s.s_wstrb[0];
          if (wren_d) addr_d = s.s_awaddr[ADDR-1:0];
          state_d     = WR_RESP;
        end else if (s.s_arvalid) begin
          s.s_arready = 1'b1;
          bad_d       = ar_bad;
          rresp_d     = ar_bad ? RESP_SLVERR : RESP_OKAY;
          rden_d      = !ar_bad;
          rdata_d     = '0;
          if (!ar_bad) addr_d = s.s_araddr[ADDR-1:0];
          state_d     = RD_WAIT;
        end
      end
      WR_RESP: begin
        if (s.s_bready) state_d = IDLE;
      end
      RD_WAIT: begin
        state_d = RD_RESP;
      end
      RD_RESP: begin
        // RdData is only guaranteed in the first response cycle; keep a copy.
        if (rd_first_q && !bad_q) rdata_d = RdData;
        if (s.s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bad_q      <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rd_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bad_q      <= bad_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      rd_first_q <= rd_first_d;
    end
  end

  assign WrEn       = wren_q;
  assign RdEn       = rden_q;
  assign Address    = addr_q;
  assign WrData     = wdata_q;
  assign s.s_bvalid = (state_q == WR_RESP);
  assign s.s_bresp  = bresp_q;
  assign s.s_rvalid = (state_q == RD_RESP);
  assign s.s_rresp  = rresp_q;
  assign s.s_rdata  = (state_q == RD_RESP && rd_first_q && !bad_q) ? RdData : rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_axi_lite_regfile_bridge.sv
// Directed bench for axi_lite_regfile_bridge with a small register-file model
// behind it; inputs change on the falling edge, outputs are checked there too.
module tb_axi_lite_regfile_bridge;

  localparam int DATA_W = 8;
  localparam int ADDR   = 6;
  localparam int DEPTH  = 6;
  localparam int AXI_AW = 8;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR-1:0]   address;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR)-1];

  axi_lite_regfile_bridge_if #(.DATA_W(DATA_W), .AXI_AW(AXI_AW)) bus ();

  axi_lite_regfile_bridge #(
    .DATA_W(DATA_W), .ADDR(ADDR), .DEPTH(DEPTH), .AXI_AW(AXI_AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus.slave),
    .WrEn      (wr_en),
    .Address   (address),
    .WrData    (wr_data),
    .RdEn      (rd_en),
    .RdData    (rd_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register-file model: synchronous write, registered read data
  always @(posedge clk) begin
    if (wr_en) mem[address] <= wr_data;
    if (rd_en) rd_data <= mem[address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
  endtask

  task automatic drive_write(input logic [7:0] a, input logic [7:0] d, input logic s);
    bus.s_awaddr  = a;
    bus.s_awvalid = 1'b1;
    bus.s_wdata   = d;
    bus.s_wstrb   = s;
    bus.s_wvalid  = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR); i++) mem[i] = 8'(i);
    mem[1] = 8'h40;
    rd_data = '0;
    idle_inputs();
    rst_n = 1'b0;

    // reset state
    nxt(); nxt();
    chk("rst_state", dbg_state, 0);
    chk("rst_bvalid", bus.s_bvalid, 0);
    chk("rst_rvalid", bus.s_rvalid, 0);
    chk("rst_wren", wr_en, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_address", address, 0);
    chk("rst_wrdata", wr_data, 0);
    chk("rst_bresp", bus.s_bresp, 0);
    chk("rst_rresp", bus.s_rresp, 0);
    chk("rst_rdata", bus.s_rdata, 0);
    chk("rst_ready", {bus.s_awready, bus.s_wready, bus.s_arready}, 0);
    rst_n = 1'b1;

    // write idx 2
    nxt();
    drive_write(8'h02, 8'hA5, 1'b1);
    #1;
    chk("wr_awready", bus.s_awready, 1);
    chk("wr_wready", bus.s_wready, 1);
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("wr_wren", wr_en, 1);
    chk("wr_address", address, 2);
    chk("wr_wrdata", wr_data, 8'hA5);
    chk("wr_bvalid", bus.s_bvalid, 1);
    chk("wr_bresp", bus.s_bresp, 0);
    nxt();
    chk("wr_wren_low", wr_en, 0);
    chk("wr_bvalid_held", bus.s_bvalid, 1);
    bus.s_bready = 1'b1;
    nxt();
    bus.s_bready = 1'b0;
    chk("wr_b_done", bus.s_bvalid, 0);
    chk("wr_idle", dbg_state, 0);

    // lone address / lone data are not accepted
    bus.s_awaddr = 8'h03; bus.s_awvalid = 1'b1;
    #1 chk("lone_aw_ready", bus.s_awready, 0);
    nxt();
    chk("lone_aw_state", dbg_state, 0);
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b1;
    #1 chk("lone_w_ready", bus.s_wready, 0);
    nxt();
    chk("lone_w_wren", wr_en, 0);
    bus.s_wvalid = 1'b0;

    // read idx 1, then hold rready low with a second read pending
    bus.s_araddr = 8'h01; bus.s_arvalid = 1'b1;
    #1 chk("rd_arready", bus.s_arready, 1);
    nxt();
    bus.s_araddr = 8'h02;
    chk("rd_rden", rd_en, 1);
    chk("rd_address", address, 1);
    chk("rd_rvalid_early", bus.s_rvalid, 0);
    nxt();
    chk("rd_rvalid", bus.s_rvalid, 1);
    chk("rd_rdata", bus.s_rdata, 8'h40);
    chk("rd_rresp", bus.s_rresp, 0);
    chk("rd_rden_low", rd_en, 0);
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("bp_rvalid", bus.s_rvalid, 1);
      chk("bp_rdata", bus.s_rdata, 8'h40);
      chk("bp_arready", bus.s_arready, 0);
    end
    bus.s_rready = 1'b1;
    nxt();
    chk("rd2_arready", bus.s_arready, 1);
    chk("rd2_rvalid_low", bus.s_rvalid, 0);
    nxt();
    bus.s_arvalid = 1'b0;
    chk("rd2_rden", rd_en, 1);
    chk("rd2_address", address, 2);
    nxt();
    chk("rd2_rvalid", bus.s_rvalid, 1);
    chk("rd2_rdata", bus.s_rdata, 8'hA5);
    nxt();
    bus.s_rready = 1'b0;
    chk("rd2_done", bus.s_rvalid, 0);

    // out-of-range write (index 6) and read (upper address bit set)
    drive_write(8'h06, 8'h11, 1'b1);
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("bad_wr_wren", wr_en, 0);
    chk("bad_wr_bvalid", bus.s_bvalid, 1);
    chk("bad_wr_bresp", bus.s_bresp, 2);
    chk("bad_wr_address", address, 2);
    bus.s_bready = 1'b1;
    nxt();
    bus.s_bready = 1'b0;
    bus.s_araddr = 8'h47; bus.s_arvalid = 1'b1;
    nxt();
    bus.s_arvalid = 1'b0;
    chk("bad_rd_rden", rd_en, 0);
    nxt();
    chk("bad_rd_rvalid", bus.s_rvalid, 1);
    chk("bad_rd_rresp", bus.s_rresp, 2);
    chk("bad_rd_rdata", bus.s_rdata, 0);
    bus.s_rready = 1'b1;
    nxt();
    bus.s_rready = 1'b0;
    chk("bad_rd_done", bus.s_rvalid, 0);
    chk("bad_wr_mem6", mem[6], 8'h06);

    // write and read arrive together: write wins, read follows the B handshake
    drive_write(8'h03, 8'h3C, 1'b1);
    bus.s_araddr = 8'h03; bus.s_arvalid = 1'b1;
    #1;
    chk("both_awready", bus.s_awready, 1);
    chk("both_arready", bus.s_arready, 0);
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("both_wren", wr_en, 1);
    chk("both_arready_wr", bus.s_arready, 0);
    bus.s_bready = 1'b1;
    nxt();
    bus.s_bready = 1'b0;
    chk("both_b_done", bus.s_bvalid, 0);
    chk("both_arready_after", bus.s_arready, 1);
    nxt();
    bus.s_arvalid = 1'b0;
    chk("both_rden", rd_en, 1);
    chk("both_rd_address", address, 3);
    nxt();
    chk("both_rdata", bus.s_rdata, 8'h3C);
    bus.s_rready = 1'b1;
    nxt();
    bus.s_rready = 1'b0;
    chk("both_idle", dbg_state, 0);

    // reset asserted while the write response is pending
    drive_write(8'h04, 8'h77, 1'b1);
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("mid_bvalid", bus.s_bvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bus.s_bvalid, 0);
    chk("mid_rst_wren", wr_en, 0);
    chk("mid_rst_state", dbg_state, 0);
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("post_rst_bvalid", bus.s_bvalid, 0);
    chk("post_rst_rvalid", bus.s_rvalid, 0);
    chk("post_rst_state", dbg_state, 0);

    // zero-strobe write to a good address: OKAY, no WrEn
    drive_write(8'h05, 8'h99, 1'b0);
    nxt();
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    chk("nostrb_wren", wr_en, 0);
    chk("nostrb_bvalid", bus.s_bvalid, 1);
    chk("nostrb_bresp", bus.s_bresp, 0);
    bus.s_bready = 1'b1;
    nxt();
    bus.s_bready = 1'b0;
    chk("nostrb_mem5", mem[5], 8'h05);
    chk("nostrb_done", bus.s_bvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile_bridge.md
# axi_lite_regfile_bridge

AXI4-Lite slave front end that drives the UHCI register file's single-port access interface (WrEn/Address/WrData/RdEn/RdData). It sits between the host-side AXI-Lite interconnect and the register file. It serialises write and read transactions, decodes out-of-range addresses, and returns B/R responses with fixed, cycle-exact latency.

## Interface
Parameters:
- DATA_W, 8, register/AXI data width; exactly one strobe bit per byte.
- ADDR, 6, register-file address width.
- DEPTH, 6, number of implemented registers; valid indices are 0..DEPTH-1.
- AXI_AW, 8, AXI address width; AXI_AW >= ADDR.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_awaddr  in  AXI_AW  write address, byte address.
- s_awvalid / s_awready  in / out  1  write-address handshake.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  write strobe.
- s_wvalid / s_wready  in / out  1  write-data handshake.
- s_bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- s_bvalid / s_bready  out / in  1  write-response handshake.
- s_araddr  in  AXI_AW  read address.
- s_arvalid / s_arready  in / out  1  read-address handshake.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response.
- s_rvalid / s_rready  out / in  1  read-data handshake.
- WrEn  out  1  register-file write pulse.
- Address  out  ADDR  register-file index.
- WrData  out  DATA_W  register-file write data.
- RdEn  out  1  register-file read pulse.
- RdData  in  DATA_W  register-file read data; registered by the register file one cycle after RdEn.

## Operation
- FSM states: IDLE, WR_RESP, RD_WAIT, RD_RESP. At most one transaction is outstanding.
- Address decode: index = addr[ADDR-1:0].
  - The address is bad if addr[AXI_AW-1:ADDR] != 0 or index >= DEPTH.
  - Bad addresses generate no WrEn/RdEn and respond SLVERR.
- IDLE, write accept:
  - If s_awvalid && s_wvalid, assert s_awready = s_wready = 1 combinationally.
  - Register the address and data, then go to WR_RESP.
  - A lone s_awvalid or a lone s_wvalid is not accepted; ready stays 0.
- IDLE, read accept:
  - If s_arvalid and no write is accepted this cycle, assert s_arready = 1 combinationally and go to RD_WAIT.
  - Writes have priority when both arrive together.
- WR_RESP:
  - WrEn pulses for exactly the first cycle of the state, but only when the address is good and s_wstrb[0] = 1.
  - A good address with zero strobe gives OKAY and no WrEn.
  - s_bvalid = 1 with s_bresp held; return to IDLE on s_bvalid && s_bready.
- RD_WAIT, one cycle: RdEn = 1 if the address is good.
- RD_RESP:
  - s_rvalid = 1.
  - s_rdata = RdData when the address is good; otherwise 0 with SLVERR.
  - s_rdata/s_rresp are held stable until s_rready; return to IDLE on handshake.
- WrEn and RdEn are never high in the same cycle.
- Address is driven from the latched index whenever WrEn or RdEn is high; otherwise it holds its last value.

## Timing
- Reset values:
  - State IDLE.
  - s_awready, s_wready, s_arready, s_bvalid, s_rvalid, WrEn, RdEn = 0.
  - s_bresp, s_rresp, s_rdata, Address, WrData = 0.
- Write: handshake at cycle T -> WrEn and s_bvalid high at T+1. Earliest next accept is the cycle after the B handshake. Minimum 2 cycles per write.
- Read: handshake at T -> RdEn high at T+1 -> s_rvalid high at T+2 with RdData. Minimum 3 cycles per read.
- Back-pressure: s_bready/s_rready low holds the response indefinitely; no new accepts happen meanwhile.
- Reset asserted mid-transaction aborts it immediately. All valids and pulses go low and no response is issued after reset release.

## Test plan
- Write idx 2 (awaddr 0x02, wdata 0xA5, wstrb 1) -> T+1: WrEn = 1, Address = 2, WrData = 0xA5, s_bvalid = 1, s_bresp = 00; WrEn low at T+2.
- Read idx 1 after reset with an RdData model (register 1 = 0x40) -> RdEn at T+1, s_rvalid at T+2, s_rdata = 0x40, s_rresp = 00.
- awaddr 0x06 and araddr 0x47 -> no WrEn/RdEn; s_bresp = 10; s_rresp = 10 with s_rdata = 0x00.
- s_awvalid, s_wvalid and s_arvalid all high in the same cycle -> write accepted first (s_arready = 0); read accepted in the cycle after the B handshake.
- s_rready held low for 5 cycles -> s_rvalid and s_rdata stable throughout; s_arready stays 0 for a pending second read.
- rst_n dropped while s_bvalid = 1 -> s_bvalid = 0 asynchronously; FSM in IDLE after release; wstrb = 0 write gives OKAY with no WrEn.
